// File: rtl/vector_deserializer.sv
// Packs BEATS narrow input words into one wide vector and presents it on a
// valid/ready output. A second completed vector can wait in the assembly buffer.
module vector_deserializer #(
  parameter int DATAWIDTH = 256,
  parameter int WORDWIDTH = 32,
  localparam int BEATS = DATAWIDTH / WORDWIDTH,
  localparam int CNTW = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [WORDWIDTH-1:0] in_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [DATAWIDTH-1:0] out_data_o,
  output logic [CNTW-1:0]      beat_cnt_o,
  output logic                 busy_o
);

  generate
    if ((DATAWIDTH % WORDWIDTH) != 0 || BEATS < 1) begin : g_width_check
      $error("DATAWIDTH must be a nonzero integer multiple of WORDWIDTH");
    end
  endgenerate

  logic [CNTW-1:0]      cnt_q;
  logic [DATAWIDTH-1:0] asm_q;
  logic [DATAWIDTH-1:0] asm_wr;
  logic [DATAWIDTH-1:0] out_data_q;
  logic                 asm_full_q;
  logic                 out_valid_q;
  logic                 in_fire;
  logic                 out_fire;
  logic                 last_beat;
  logic                 slot_free;

  // Handshakes: a beat/vector transfers on a rising clk_i edge where both
  // valid and ready are high; valid, once high, holds with stable data until
  // it transfers (only en_i low or reset withdraw it).
  assign in_ready_o  = rst_ni & en_i & ~flush_i & ~asm_full_q;
  assign out_valid_o = out_valid_q & en_i;
  assign out_data_o  = out_data_q;
  assign beat_cnt_o  = cnt_q;
  assign busy_o      = (cnt_q != '0) | asm_full_q | out_valid_q;

  assign in_fire   = in_valid_i & in_ready_o;
  assign out_fire  = out_valid_o & out_ready_i;
  assign last_beat = (cnt_q == CNTW'(BEATS - 1));
  assign slot_free = ~out_valid_q | out_fire;

  // Assembly buffer with the current beat merged into its slice.
  always_comb begin
    asm_wr = asm_q;
    for (int k = 0; k < BEATS; k++) begin
      if (cnt_q == CNTW'(k)) asm_wr[k*WORDWIDTH +: WORDWIDTH] = in_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q       <= '0;
      asm_q       <= '0;
      asm_full_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (!en_i) begin
      cnt_q       <= '0;
      asm_q       <= '0;
      asm_full_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      if (asm_full_q && out_fire) begin
        out_data_q <= asm_q;
        asm_q      <= '0;
        asm_full_q <= 1'b0;
      end else if (out_fire) begin
        out_valid_q <= 1'b0;
      end

      // in_fire implies !asm_full_q, so this never collides with the drain above.
      if (in_fire) begin
        if (last_beat) begin
          cnt_q <= '0;
          if (slot_free) begin
            out_data_q  <= asm_wr;
            out_valid_q <= 1'b1;
            asm_q       <= '0;
          end else begin
            asm_q      <= asm_wr;
            asm_full_q <= 1'b1;
          end
        end else begin
          cnt_q <= cnt_q + CNTW'(1);
          asm_q <= asm_wr;
        end
      end else if (flush_i && !asm_full_q) begin
        cnt_q <= '0;
        asm_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vector_deserializer.sv
// Randomized bench for vector_deserializer checked against a queue-based
// model: partial beats in part_q, completed vectors (output slot first) in exp_q.
module tb_vector_deserializer;
  localparam int DW    = 256;
  localparam int WW    = 32;
  localparam int BEATS = DW / WW;
  localparam int CNTW  = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            en;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [WW-1:0]   in_data;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic [CNTW-1:0] beat_cnt;
  logic            busy;

  int total_cnt = 0;
  int pass_cnt  = 0;

  logic [WW-1:0] part_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] slot_data = '0;

  vector_deserializer #(.DATAWIDTH(DW), .WORDWIDTH(WW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .beat_cnt_o(beat_cnt), .busy_o(busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model
  function automatic logic m_in_ready();
    return rst_n && en && !flush && (exp_q.size() < 2);
  endfunction

  function automatic logic m_out_valid();
    return rst_n && en && (exp_q.size() > 0);
  endfunction

  function automatic logic [CNTW-1:0] m_cnt();
    return CNTW'(part_q.size());
  endfunction

  function automatic logic m_busy();
    return (part_q.size() != 0) || (exp_q.size() > 0);
  endfunction

  function automatic logic [DW-1:0] pack_part();
    logic [DW-1:0] v;
    v = '0;
    for (int k = 0; k < part_q.size(); k++) v[k*WW +: WW] = part_q[k];
    return v;
  endfunction

  task automatic model_clear();
    part_q.delete();
    exp_q.delete();
    slot_data = '0;
  endtask

  // One clock edge: model follows the inputs held across the edge.
  task automatic step();
    logic          ofire, ifire, fl, e;
    logic [WW-1:0] d;
    ofire = m_out_valid() && out_ready;
    ifire = in_valid && m_in_ready();
    fl = flush;
    e = en;
    d = in_data;
    @(posedge clk);
    if (!e) begin
      model_clear();
    end else begin
      if (ofire) void'(exp_q.pop_front());
      if (ifire) begin
        part_q.push_back(d);
        if (part_q.size() == BEATS) begin
          exp_q.push_back(pack_part());
          part_q.delete();
        end
      end else if (fl) begin
        part_q.delete();
      end
      if (exp_q.size() > 0) slot_data = exp_q[0];
    end
    #1;
  endtask

  // driver tasks
  task automatic idle(input int n);
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    model_clear();
    @(negedge clk);
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%0b exp=0", out_valid); else pass_cnt++;
    total_cnt++; if (out_data !== '0) $display("FAIL reset_out_data got=%h exp=0", out_data); else pass_cnt++;
    total_cnt++; if (beat_cnt !== '0) $display("FAIL reset_beat_cnt got=%0d exp=0", beat_cnt); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got=%0b exp=0", busy); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got=%0b exp=0", in_ready); else pass_cnt++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic [DW-1:0] v;
    out_ready = 1'b1;
    for (int i = 0; i < BEATS; i++) begin
      in_valid = 1'b1; in_data = WW'(i);
      @(negedge clk);
      total_cnt++; if (beat_cnt !== CNTW'(i)) $display("FAIL basic_cnt got=%0d exp=%0d", beat_cnt, i); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL basic_in_ready got=%0b exp=1", in_ready); else pass_cnt++;
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL basic_early_valid got=%0b exp=0", out_valid); else pass_cnt++;
      step();
    end
    in_valid = 1'b0;
    v = '0;
    for (int k = 0; k < BEATS; k++) v[k*WW +: WW] = WW'(k);
    @(negedge clk);
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL basic_valid got=%0b exp=1", out_valid); else pass_cnt++;
    total_cnt++; if (out_data !== v) $display("FAIL basic_data got=%h exp=%h", out_data, v); else pass_cnt++;
    total_cnt++; if (out_data !== slot_data) $display("FAIL basic_model_data got=%h exp=%h", out_data, slot_data); else pass_cnt++;
    total_cnt++; if (beat_cnt !== '0) $display("FAIL basic_cnt_wrap got=%0d exp=0", beat_cnt); else pass_cnt++;
    step();
    @(negedge clk);
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL basic_one_cycle got=%0b exp=0", out_valid); else pass_cnt++;
    total_cnt++; if (busy !== m_busy()) $display("FAIL basic_busy got=%0b exp=%0b", busy, m_busy()); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] v1, v2;
    v1 = '0; v2 = '0;
    for (int k = 0; k < BEATS; k++) begin
      v1[k*WW +: WW] = WW'(32'hA0 + k);
      v2[k*WW +: WW] = WW'(32'hA8 + k);
    end
    out_ready = 1'b0;
    for (int i = 0; i < 2*BEATS; i++) begin
      in_valid = 1'b1; in_data = WW'(32'hA0 + i);
      @(negedge clk);
      total_cnt++; if (in_ready !== m_in_ready()) $display("FAIL bp_in_ready beat=%0d got=%0b exp=%0b", i, in_ready, m_in_ready()); else pass_cnt++;
      total_cnt++; if (beat_cnt !== m_cnt()) $display("FAIL bp_cnt beat=%0d got=%0d exp=%0d", i, beat_cnt, m_cnt()); else pass_cnt++;
      total_cnt++; if (out_valid !== m_out_valid()) $display("FAIL bp_valid beat=%0d got=%0b exp=%0b", i, out_valid, m_out_valid()); else pass_cnt++;
      step();
    end
    in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
    @(negedge clk);
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_stall got=%0b exp=0", in_ready); else pass_cnt++;
    total_cnt++; if (out_data !== v1) $display("FAIL bp_hold_v1 got=%h exp=%h", out_data, v1); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1) $display("FAIL bp_busy got=%0b exp=1", busy); else pass_cnt++;
    step();
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    total_cnt++; if (out_valid !== 1'b1 || out_data !== v1) $display("FAIL bp_v1 got=%0b/%h exp=1/%h", out_valid, out_data, v1); else pass_cnt++;
    step();
    @(negedge clk);
    total_cnt++; if (out_valid !== 1'b1 || out_data !== v2) $display("FAIL bp_v2 got=%0b/%h exp=1/%h", out_valid, out_data, v2); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_ready_back got=%0b exp=1", in_ready); else pass_cnt++;
    step();
    @(negedge clk);
    total_cnt++; if (out_valid !== m_out_valid()) $display("FAIL bp_drained got=%0b exp=%0b", out_valid, m_out_valid()); else pass_cnt++;
  endtask

  task automatic test_flush();
    logic [DW-1:0] v;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = $urandom;
      step();
    end
    flush = 1'b1; in_valid = 1'b1; in_data = $urandom;
    @(negedge clk);
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL flush_in_ready got=%0b exp=0", in_ready); else pass_cnt++;
    step();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    total_cnt++; if (beat_cnt !== '0) $display("FAIL flush_cnt got=%0d exp=0", beat_cnt); else pass_cnt++;
    v = '0;
    for (int i = 0; i < BEATS; i++) begin
      in_valid = 1'b1; in_data = $urandom;
      v[i*WW +: WW] = in_data;
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    total_cnt++; if (out_valid !== 1'b1 || out_data !== v) $display("FAIL flush_clean_vec got=%0b/%h exp=1/%h", out_valid, out_data, v); else pass_cnt++;
    total_cnt++; if (out_data !== slot_data) $display("FAIL flush_model got=%h exp=%h", out_data, slot_data); else pass_cnt++;
    idle(1);
  endtask

  task automatic test_enable();
    logic [DW-1:0] v;
    out_ready = 1'b0;
    for (int i = 0; i < BEATS + 5; i++) begin
      in_valid = 1'b1; in_data = $urandom;
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    total_cnt++; if (out_valid !== 1'b1 || beat_cnt !== CNTW'(5)) $display("FAIL en_setup got=%0b/%0d exp=1/5", out_valid, beat_cnt); else pass_cnt++;
    en = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL en_valid_same got=%0b exp=0", out_valid); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL en_ready_same got=%0b exp=0", in_ready); else pass_cnt++;
    step();
    @(negedge clk);
    total_cnt++; if (beat_cnt !== '0) $display("FAIL en_cnt_clear got=%0d exp=0", beat_cnt); else pass_cnt++;
    total_cnt++; if (out_data !== '0) $display("FAIL en_data_clear got=%h exp=0", out_data); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL en_busy_clear got=%0b exp=0", busy); else pass_cnt++;
    step();
    en = 1'b1;
    v = '0;
    for (int i = 0; i < BEATS; i++) begin
      in_valid = 1'b1; in_data = $urandom;
      v[i*WW +: WW] = in_data;
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    total_cnt++; if (out_valid !== 1'b1 || out_data !== v) $display("FAIL en_fresh_vec got=%0b/%h exp=1/%h", out_valid, out_data, v); else pass_cnt++;
    idle(1);
  endtask

  task automatic test_async_reset();
    logic [DW-1:0] v;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = $urandom;
      step();
    end
    in_valid = 1'b1; in_data = $urandom;
    @(negedge clk);
    total_cnt++; if (beat_cnt !== m_cnt()) $display("FAIL arst_pre_cnt got=%0d exp=%0d", beat_cnt, m_cnt()); else pass_cnt++;
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    total_cnt++; if (beat_cnt !== '0) $display("FAIL arst_cnt got=%0d exp=0", beat_cnt); else pass_cnt++;
    total_cnt++; if (out_data !== '0) $display("FAIL arst_data got=%h exp=0", out_data); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) $display("FAIL arst_ctrl got=%0b%0b%0b exp=000", busy, in_ready, out_valid); else pass_cnt++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    v = '0;
    for (int i = 0; i < BEATS; i++) begin
      in_valid = 1'b1; in_data = $urandom;
      v[i*WW +: WW] = in_data;
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    total_cnt++; if (out_valid !== 1'b1 || out_data !== v) $display("FAIL arst_vec got=%0b/%h exp=1/%h", out_valid, out_data, v); else pass_cnt++;
    idle(1);
  endtask

  task automatic test_back_to_back();
    int pulses;
    logic exp_v;
    pulses = 0;
    out_ready = 1'b1;
    for (int i = 0; i <= 8*BEATS; i++) begin
      in_valid = (i < 8*BEATS); in_data = $urandom;
      exp_v = (i >= BEATS) && (i % BEATS == 0);
      @(negedge clk);
      if (i < 8*BEATS) begin
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL b2b_in_ready cyc=%0d got=%0b exp=1", i, in_ready); else pass_cnt++;
      end
      total_cnt++; if (out_valid !== exp_v) $display("FAIL b2b_valid cyc=%0d got=%0b exp=%0b", i, out_valid, exp_v); else pass_cnt++;
      if (exp_v) begin
        total_cnt++; if (out_data !== slot_data) $display("FAIL b2b_data cyc=%0d got=%h exp=%h", i, out_data, slot_data); else pass_cnt++;
      end
      if (out_valid === 1'b1) pulses++;
      step();
    end
    total_cnt++; if (pulses != 8) $display("FAIL b2b_vectors got=%0d exp=8", pulses); else pass_cnt++;
    idle(1);
  endtask

  initial begin
    test_reset();
    test_basic();
    idle(1);
    test_backpressure();
    idle(2);
    test_flush();
    test_enable();
    test_async_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
